// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle multiply/divide unit for the EX stage. Owns the HI/LO
//   architectural registers. Operands are captured when an operation is
//   accepted; HI/LO are written only when the per-op latency expires, so
//   hazard logic can stall on busy and a flush can cancel the operation.
//
//   Optional macro HILO_MADD_EN: when defined, ops 7-10 (MADD, MADDU, MSUB,
//   MSUBU) accumulate into {hi,lo}. When undefined they decode as NOP and
//   no accumulate adder exists.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   a, b    operands (rs, rt)
//   op      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//           7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU, 11-15 NOP
//   start   request, qualifies op/a/b this cycle
//   lock    pipeline freeze; start ignored while set
//   cancel  abort in-flight operation
//   busy    operation in flight
//   done    one-cycle pulse when the result is committed
//   hi, lo  HI/LO registers
module hilo_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             lock,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef HILO_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_CNT = 5'(DIV_LAT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic             accept;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [3:0]       op_p0;
  logic [W2-1:0]    res;

  function automatic logic is_long(input logic [3:0] o);
    case (o)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long = 1'b1;
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long = 1'b1;
`endif
      default: is_long = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] lat_of(input logic [3:0] o);
    lat_of = (o == OP_DIV || o == OP_DIVU) ? DIV_CNT : MUL_CNT;
  endfunction

  // Full-width product; operands extended to 2*WIDTH so the low 2*WIDTH
  // bits of the multiply are the exact signed or unsigned product.
  function automatic logic [W2-1:0] mul_full(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             sgn);
    logic signed [W2-1:0] xe;
    logic signed [W2-1:0] ye;
    xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    mul_full = xe * ye;
  endfunction

  // Returns {remainder, quotient}. Divide by zero yields quotient all ones
  // and remainder = dividend; signed MIN/-1 yields quotient MIN, rem 0.
  function automatic logic [W2-1:0] div_full(input logic [WIDTH-1:0] n,
                                             input logic [WIDTH-1:0] d,
                                             input logic             sgn);
    logic signed [WIDTH-1:0] ns;
    logic signed [WIDTH-1:0] ds;
    logic [WIDTH-1:0]        q;
    logic [WIDTH-1:0]        r;
    ns = n;
    ds = d;
    if (d == '0) begin
      q = '1;
      r = n;
    end else if (sgn && n == {1'b1, {(WIDTH-1){1'b0}}} && d == '1) begin
      q = n;
      r = '0;
    end else if (sgn) begin
      q = ns / ds;
      r = ns % ds;
    end else begin
      q = n / d;
      r = n % d;
    end
    div_full = {r, q};
  endfunction

  assign accept = start && !lock && !cancel && (state == IDLE);
  assign busy   = (state == RUN);

  // Capture stage: operands held for the duration of the operation.
  always_ff @(posedge clk) begin
    if (accept && is_long(op)) begin
      a_p0  <= a;
      b_p0  <= b;
      op_p0 <= op;
    end
  end

  // Commit stage: result evaluated from captured operands and current HI/LO.
  always_comb begin
    res = {hi, lo};
    case (op_p0)
      OP_MULT:  res = mul_full(a_p0, b_p0, 1'b1);
      OP_MULTU: res = mul_full(a_p0, b_p0, 1'b0);
      OP_DIV:   res = div_full(a_p0, b_p0, 1'b1);
      OP_DIVU:  res = div_full(a_p0, b_p0, 1'b0);
`ifdef HILO_MADD_EN
      OP_MADD:  res = {hi, lo} + mul_full(a_p0, b_p0, 1'b1);
      OP_MADDU: res = {hi, lo} + mul_full(a_p0, b_p0, 1'b0);
      OP_MSUB:  res = {hi, lo} - mul_full(a_p0, b_p0, 1'b1);
      OP_MSUBU: res = {hi, lo} - mul_full(a_p0, b_p0, 1'b0);
`endif
      default:  res = {hi, lo};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else if (is_long(op)) begin
              state <= RUN;
              cnt   <= lat_of(op);
            end
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= res;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        start;
  logic        lock;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .lock(lock), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the next posedge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int lat,
                       input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, x, y);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    reset = 1'b1; a = '0; b = '0; op = '0; start = 1'b0; lock = 1'b0; cancel = 1'b0;
    #2;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    do_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_zero", 4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
    do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE);

    // MTHI / MTLO write at the accept edge without busy
    issue(4'd5, 32'd9, 32'd0);
    check("mthi_hi", 64'(hi), 64'd9);
    check("mthi_busy", 64'(busy), 64'd0);
    issue(4'd6, 32'h1234, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi", 64'(hi), 64'd9);
    check("mtlo_busy", 64'(busy), 64'd0);

    // Second start while busy is ignored
    issue(4'd1, 32'd3, 32'd4);
    @(negedge clk);
    issue(4'd1, 32'd5, 32'd6);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("b2b_dones", 64'(dones), 64'd1);
    check("b2b_hi", 64'(hi), 64'd0);
    check("b2b_lo", 64'(lo), 64'd12);

    // lock and cancel block a start in IDLE
    lock = 1'b1;
    issue(4'd1, 32'd7, 32'd7);
    lock = 1'b0;
    check("lock_busy", 64'(busy), 64'd0);
    cancel = 1'b1;
    issue(4'd1, 32'd7, 32'd7);
    cancel = 1'b0;
    check("cancel_idle_busy", 64'(busy), 64'd0);

    // Cancel in cycle 3 of a MULTU
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("cancel_dones", 64'(dones), 64'd0);
    check("cancel_hi", 64'(hi), 64'd0);
    check("cancel_lo", 64'(lo), 64'd12);

    // Async reset mid-run
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_done", 64'(done), 64'd0);

`ifdef HILO_MADD_EN
    issue(4'd5, 32'd1, 32'd0);
    issue(4'd6, 32'd0, 32'd0);
    do_op("maddu", 4'd8, 32'd2, 32'd3, 5, 32'd1, 32'd6);
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd0, 32'd0);
    do_op("msub", 4'd9, 32'd1, 32'd1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue(4'd5, 32'd3, 32'd0);
    issue(4'd7, 32'd2, 32'd3);
    check("madd_off_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("madd_off_busy2", 64'(busy), 64'd0);
    check("madd_off_hi", 64'(hi), 64'd3);
    check("madd_off_lo", 64'(lo), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
